// File: rtl/rgb_pixel_assembler_pkg.sv
// Shared types for the RGB pixel assembler: luma coefficients, FSM states
// and the pixel record carried through the output FIFO.
package pix_pkg;

  localparam int LUMA_R = 77;
  localparam int LUMA_G = 150;
  localparam int LUMA_B = 29;

  // Coordinate widths of the stored record; the top refuses other geometries.
  localparam int REC_WIDTH  = 24;
  localparam int REC_HEIGHT = 24;
  localparam int REC_XW     = $clog2(REC_WIDTH);
  localparam int REC_YW     = $clog2(REC_HEIGHT);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef struct packed {
    logic [23:0]       rgb;
    logic [7:0]        gray;
    logic [REC_XW-1:0] x;
    logic [REC_YW-1:0] y;
    logic              sof;
    logic              eol;
    logic              eof;
  } pix_rec_t;

  // Weights sum to 256, so a 16-bit unsigned accumulator never overflows.
  function automatic logic [7:0] luma(input logic [7:0] r, input logic [7:0] g,
                                      input logic [7:0] b);
    return 8'((16'(LUMA_R) * {8'd0, r} + 16'(LUMA_G) * {8'd0, g}
               + 16'(LUMA_B) * {8'd0, b}) >> 8);
  endfunction

endpackage

// File: rtl/rgb_pixel_assembler_if.sv
// Valid/ready pixel stream from the assembler to the processing pipeline.
interface rgb_pixel_assembler_if #(
  parameter int XW = 5,
  parameter int YW = 5
);
  logic          pix_valid;
  logic          pix_ready;
  logic [23:0]   pix_rgb;
  logic [7:0]    pix_gray;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic          pix_sof;
  logic          pix_eol;
  logic          pix_eof;

  modport master (
    output pix_valid, pix_rgb, pix_gray, pix_x, pix_y, pix_sof, pix_eol, pix_eof,
    input  pix_ready
  );

  modport slave (
    input  pix_valid, pix_rgb, pix_gray, pix_x, pix_y, pix_sof, pix_eol, pix_eof,
    output pix_ready
  );
endinterface

// File: rtl/pix_fifo.sv
// First-word-fall-through FIFO with synchronous flush; a push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module pix_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/rgb_pixel_assembler.sv
// Groups image_loader's byte stream into RGB pixels with coordinates, luma and
// frame flags, and queues them for a valid/ready consumer.
module rgb_pixel_assembler
  import pix_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 24,
  parameter int IMAGE_HEIGHT = 24,
  parameter int CHANNELS     = 3,
  parameter int ADDR_WIDTH   = 20,
  parameter int FIFO_DEPTH   = 4,
  parameter int XW           = $clog2(IMAGE_WIDTH),
  parameter int YW           = $clog2(IMAGE_HEIGHT)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [7:0]              pixel_data,
  input  logic [ADDR_WIDTH-1:0]   pixel_addr,
  input  logic                    pixel_we,
  rgb_pixel_assembler_if.master   pix,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    overflow,
  output logic                    addr_err
);
  localparam int TOTAL_BYTES = IMAGE_WIDTH * IMAGE_HEIGHT * CHANNELS;
  localparam logic [XW-1:0] X_LAST = XW'(IMAGE_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMAGE_HEIGHT - 1);

  if (CHANNELS != 3) begin : g_bad_channels
    $error("rgb_pixel_assembler: only CHANNELS=3 is supported");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("rgb_pixel_assembler: FIFO_DEPTH must be a power of 2 and at least 2");
  end
  if (XW != REC_XW || YW != REC_YW) begin : g_bad_geometry
    $error("rgb_pixel_assembler: coordinate widths must match pix_pkg record");
  end

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] exp_addr_q, exp_addr_d;
  logic [1:0]            ch_q, ch_d;
  logic [7:0]            r_q, r_d, g_q, g_d;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic                  asm_valid_q, asm_valid_d;
  logic [23:0]           asm_rgb_q, asm_rgb_d;
  logic [XW-1:0]         asm_x_q, asm_x_d;
  logic [YW-1:0]         asm_y_q, asm_y_d;
  logic                  asm_sof_q, asm_sof_d;
  logic                  asm_eol_q, asm_eol_d;
  logic                  asm_eof_q, asm_eof_d;
  logic                  overflow_q, overflow_d;
  logic                  addr_err_q, addr_err_d;
  pix_rec_t              hold_q, hold_d;

  pix_rec_t fifo_din, fifo_dout, pix_sel;
  logic     fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic     we_run, addr_match, byte_ok, byte_bad, drop, eof_gone;

  // Gray is computed on the way into the FIFO, one edge after assembly.
  assign fifo_din = '{rgb: asm_rgb_q,
                      gray: luma(asm_rgb_q[23:16], asm_rgb_q[15:8], asm_rgb_q[7:0]),
                      x: asm_x_q, y: asm_y_q,
                      sof: asm_sof_q, eol: asm_eol_q, eof: asm_eof_q};

  assign fifo_push  = asm_valid_q;
  assign fifo_pop   = !fifo_empty && pix.pix_ready;
  assign drop       = asm_valid_q && fifo_full && !fifo_pop;
  assign eof_gone   = (fifo_pop && fifo_dout.eof) || (drop && asm_eof_q);

  assign we_run     = (state_q == RUN) && pixel_we && !start;
  assign addr_match = (exp_addr_q < ADDR_WIDTH'(TOTAL_BYTES)) && (pixel_addr == exp_addr_q);
  assign byte_ok    = we_run && addr_match;
  assign byte_bad   = we_run && !addr_match;

  pix_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH($bits(pix_rec_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (start),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    exp_addr_d  = exp_addr_q;
    ch_d        = ch_q;
    r_d         = r_q;
    g_d         = g_q;
    x_d         = x_q;
    y_d         = y_q;
    asm_valid_d = 1'b0;
    asm_rgb_d   = asm_rgb_q;
    asm_x_d     = asm_x_q;
    asm_y_d     = asm_y_q;
    asm_sof_d   = asm_sof_q;
    asm_eol_d   = asm_eol_q;
    asm_eof_d   = asm_eof_q;
    overflow_d  = overflow_q;
    addr_err_d  = addr_err_q;
    hold_d      = fifo_pop ? fifo_dout : hold_q;

    if (start) begin
      state_d    = RUN;
      exp_addr_d = '0;
      ch_d       = '0;
      x_d        = '0;
      y_d        = '0;
      overflow_d = 1'b0;
      addr_err_d = 1'b0;
    end else begin
      if (byte_ok) begin
        exp_addr_d = exp_addr_q + 1'b1;
        if (ch_q == 2'd0) r_d = pixel_data;
        if (ch_q == 2'd1) g_d = pixel_data;
        if (ch_q == 2'd2) begin
          ch_d        = '0;
          asm_valid_d = 1'b1;
          asm_rgb_d   = {r_q, g_q, pixel_data};
          asm_x_d     = x_q;
          asm_y_d     = y_q;
          asm_sof_d   = (x_q == '0) && (y_q == '0);
          asm_eol_d   = (x_q == X_LAST);
          asm_eof_d   = (x_q == X_LAST) && (y_q == Y_LAST);
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
        end else begin
          ch_d = ch_q + 1'b1;
        end
      end
      if (byte_bad) addr_err_d = 1'b1;
      if (drop)     overflow_d = 1'b1;
      if (state_q == RUN && eof_gone) state_d = DONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      exp_addr_q  <= '0;
      ch_q        <= '0;
      r_q         <= '0;
      g_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      asm_valid_q <= 1'b0;
      asm_rgb_q   <= '0;
      asm_x_q     <= '0;
      asm_y_q     <= '0;
      asm_sof_q   <= 1'b0;
      asm_eol_q   <= 1'b0;
      asm_eof_q   <= 1'b0;
      overflow_q  <= 1'b0;
      addr_err_q  <= 1'b0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      exp_addr_q  <= exp_addr_d;
      ch_q        <= ch_d;
      r_q         <= r_d;
      g_q         <= g_d;
      x_q         <= x_d;
      y_q         <= y_d;
      asm_valid_q <= asm_valid_d;
      asm_rgb_q   <= asm_rgb_d;
      asm_x_q     <= asm_x_d;
      asm_y_q     <= asm_y_d;
      asm_sof_q   <= asm_sof_d;
      asm_eol_q   <= asm_eol_d;
      asm_eof_q   <= asm_eof_d;
      overflow_q  <= overflow_d;
      addr_err_q  <= addr_err_d;
      hold_q      <= hold_d;
    end
  end

  // With the FIFO empty the fields keep showing the last transferred pixel.
  assign pix_sel       = fifo_empty ? hold_q : fifo_dout;
  assign pix.pix_valid = !fifo_empty;
  assign pix.pix_rgb   = pix_sel.rgb;
  assign pix.pix_gray  = pix_sel.gray;
  assign pix.pix_x     = pix_sel.x;
  assign pix.pix_y     = pix_sel.y;
  assign pix.pix_sof   = pix_sel.sof;
  assign pix.pix_eol   = pix_sel.eol;
  assign pix.pix_eof   = pix_sel.eof;

  assign busy       = (state_q == RUN);
  assign frame_done = (state_q == DONE);
  assign overflow   = overflow_q;
  assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_rgb_pixel_assembler.sv
// Directed bench for rgb_pixel_assembler: full frames, luma corner cases,
// backpressure overflow, address errors, restart and asynchronous reset.
module tb_rgb_pixel_assembler;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  pixel_data;
  logic [19:0] pixel_addr;
  logic        pixel_we;
  logic        busy;
  logic        frame_done;
  logic        overflow;
  logic        addr_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int recv, coord_err, eol_cnt, sof_cnt, eof_cnt, eof_cycle, fd_cycle;
  logic [23:0] p0_rgb, p23_rgb, p575_rgb;
  logic [7:0]  p0_gray, p23_gray;
  logic        p0_sof, p23_eol, p575_eof;

  rgb_pixel_assembler_if #(.XW(5), .YW(5)) pix_bus ();

  rgb_pixel_assembler #(
    .IMAGE_WIDTH (24),
    .IMAGE_HEIGHT(24),
    .CHANNELS    (3),
    .ADDR_WIDTH  (20),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .pixel_data(pixel_data),
    .pixel_addr(pixel_addr),
    .pixel_we  (pixel_we),
    .pix       (pix_bus),
    .busy      (busy),
    .frame_done(frame_done),
    .overflow  (overflow),
    .addr_err  (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send_byte(input int addr, input int data);
    pixel_addr = 20'(addr);
    pixel_data = 8'(data);
    pixel_we   = 1'b1;
    tick();
    pixel_we   = 1'b0;
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Records the pixel presented this cycle; pix_ready is high in this test.
  task automatic observe();
    if (pix_bus.pix_valid) begin
      if (32'(pix_bus.pix_x) != recv % 24 || 32'(pix_bus.pix_y) != recv / 24) coord_err++;
      if (pix_bus.pix_eol) eol_cnt++;
      if (pix_bus.pix_sof) sof_cnt++;
      if (pix_bus.pix_eof) begin
        eof_cnt++;
        eof_cycle = cyc;
      end
      if (recv == 0) begin
        p0_rgb = pix_bus.pix_rgb; p0_gray = pix_bus.pix_gray; p0_sof = pix_bus.pix_sof;
      end
      if (recv == 23) begin
        p23_rgb = pix_bus.pix_rgb; p23_gray = pix_bus.pix_gray; p23_eol = pix_bus.pix_eol;
      end
      if (recv == 575) begin
        p575_rgb = pix_bus.pix_rgb; p575_eof = pix_bus.pix_eof;
      end
      recv++;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; pixel_we = 1'b0; pixel_data = '0; pixel_addr = '0;
    pix_bus.pix_ready = 1'b0;
    recv = 0; coord_err = 0; eol_cnt = 0; sof_cnt = 0; eof_cnt = 0;
    eof_cycle = -100; fd_cycle = -1;
    p0_rgb = 'x; p23_rgb = 'x; p575_rgb = 'x; p0_gray = 'x; p23_gray = 'x;
    p0_sof = 'x; p23_eol = 'x; p575_eof = 'x;
    repeat (3) tick();
    check("rst_valid", 32'(pix_bus.pix_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(frame_done), 0);
    check("rst_rgb", 32'(pix_bus.pix_rgb), 0);
    rst_n = 1'b1;
    tick();
    send_byte(0, 8'h55);
    check("idle_ignores_we", 32'({busy, addr_err, pix_bus.pix_valid}), 0);

    // Full frame, consumer always ready.
    pix_bus.pix_ready = 1'b1;
    start_frame();
    for (int i = 0; i < 1728; i++) begin
      pixel_addr = 20'(i);
      pixel_data = 8'(i);
      pixel_we   = 1'b1;
      tick();
      observe();
    end
    pixel_we = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      observe();
      if (frame_done) begin
        fd_cycle = cyc;
        break;
      end
    end
    check("f1_count", recv, 576);
    check("f1_coords", coord_err, 0);
    check("f1_p0_rgb", 32'(p0_rgb), 32'h000102);
    check("f1_p0_gray", 32'(p0_gray), 0);          // (150*1 + 29*2) >> 8
    check("f1_p0_sof", 32'(p0_sof), 1);
    check("f1_p23_rgb", 32'(p23_rgb), 32'h454647);
    check("f1_p23_gray", 32'(p23_gray), 69);       // (77*69 + 150*70 + 29*71) >> 8
    check("f1_p23_eol", 32'(p23_eol), 1);
    check("f1_p575_rgb", 32'(p575_rgb), 32'hBDBEBF);
    check("f1_p575_eof", 32'(p575_eof), 1);
    check("f1_eol_cnt", eol_cnt, 24);
    check("f1_sof_cnt", sof_cnt, 1);
    check("f1_eof_cnt", eof_cnt, 1);
    check("f1_done_lat", fd_cycle - eof_cycle, 1);
    check("f1_busy", 32'(busy), 0);
    check("f1_flags", 32'({overflow, addr_err}), 0);

    // Luma extremes and output latency.
    start_frame();
    send_byte(0, 255); send_byte(1, 255); send_byte(2, 255);
    check("lat_n", 32'(pix_bus.pix_valid), 0);
    tick();
    check("lat_n1", 32'(pix_bus.pix_valid), 1);
    check("white_gray", 32'(pix_bus.pix_gray), 255);
    check("white_rgb", 32'(pix_bus.pix_rgb), 32'hFFFFFF);
    send_byte(3, 8'h4C); send_byte(4, 0); send_byte(5, 0);
    check("red_lat_n", 32'(pix_bus.pix_valid), 0);
    tick();
    check("red_valid", 32'(pix_bus.pix_valid), 1);
    check("red_gray", 32'(pix_bus.pix_gray), 22);  // 77*76 >> 8
    check("red_x", 32'(pix_bus.pix_x), 1);

    // Stalled consumer: only the first FIFO_DEPTH pixels survive.
    pix_bus.pix_ready = 1'b0;
    start_frame();
    for (int i = 0; i < 12; i++) send_byte(i, i);
    tick();
    check("ovf_4th_ok", 32'({pix_bus.pix_valid, overflow}), 32'b10);
    for (int i = 12; i < 15; i++) send_byte(i, i);
    tick();
    check("ovf_5th", 32'(overflow), 1);
    for (int i = 15; i < 1728; i++) send_byte(i, i);
    check("ovf_done_pre", 32'(frame_done), 0);
    tick();
    check("ovf_done", 32'({frame_done, busy}), 32'b10);
    pix_bus.pix_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      check("ovf_valid", 32'(pix_bus.pix_valid), 1);
      check("ovf_xy", 32'({pix_bus.pix_y, pix_bus.pix_x}), 32'(j));
      if (j == 0) check("ovf_p0_rgb", 32'(pix_bus.pix_rgb), 32'h000102);
      if (j == 3) check("ovf_p3_rgb", 32'(pix_bus.pix_rgb), 32'h090A0B);
      tick();
    end
    check("ovf_drained", 32'(pix_bus.pix_valid), 0);
    check("ovf_hold_x", 32'(pix_bus.pix_x), 3);
    pix_bus.pix_ready = 1'b0;

    // Out-of-order address is dropped and flagged.
    start_frame();
    check("ae_cleared", 32'({overflow, addr_err, frame_done, busy}), 32'b0001);
    for (int i = 0; i < 6; i++) send_byte(i, 8'h10 + i);
    send_byte(7, 8'h99);
    check("ae_set", 32'(addr_err), 1);
    send_byte(6, 8'h16); send_byte(7, 8'h17); send_byte(8, 8'h18);
    tick();
    pix_bus.pix_ready = 1'b1;
    check("ae_p0_rgb", 32'(pix_bus.pix_rgb), 32'h101112);
    tick();
    check("ae_p1_rgb", 32'(pix_bus.pix_rgb), 32'h131415);
    tick();
    check("ae_p2_rgb", 32'(pix_bus.pix_rgb), 32'h161718);
    check("ae_p2_x", 32'(pix_bus.pix_x), 2);
    check("ae_p2_gray", 32'(pix_bus.pix_gray), 22); // (77*22 + 150*23 + 29*24) >> 8
    pix_bus.pix_ready = 1'b0;

    // Restart mid-frame with pixels queued.
    start_frame();
    for (int i = 0; i < 6; i++) send_byte(i, 8'h20 + i);
    send_byte(9, 0);
    tick();
    check("rs_queued", 32'({pix_bus.pix_valid, addr_err}), 32'b11);
    start_frame();
    check("rs_flushed", 32'({pix_bus.pix_valid, addr_err, overflow, busy}), 32'b0001);
    send_byte(0, 8'hA0); send_byte(1, 8'hA1); send_byte(2, 8'hA2);
    tick();
    check("rs_new_p0", 32'({pix_bus.pix_valid, pix_bus.pix_sof, pix_bus.pix_y, pix_bus.pix_x}),
          32'b1_1_00000_00000);
    check("rs_new_rgb", 32'(pix_bus.pix_rgb), 32'hA0A1A2);

    // Asynchronous reset in the middle of a cycle.
    send_byte(3, 1); send_byte(4, 2); send_byte(9, 3);
    check("ar_pre", 32'({busy, addr_err, pix_bus.pix_valid}), 32'b111);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_ctrl", 32'({pix_bus.pix_valid, busy, frame_done, overflow, addr_err}), 0);
    check("ar_fields", 32'({pix_bus.pix_gray, pix_bus.pix_rgb}), 0);
    check("ar_xy", 32'({pix_bus.pix_sof, pix_bus.pix_eol, pix_bus.pix_eof,
                        pix_bus.pix_y, pix_bus.pix_x}), 0);
    tick();
    rst_n = 1'b1;
    send_byte(0, 1); send_byte(1, 2); send_byte(2, 3);
    tick(); tick();
    check("ar_stays_idle", 32'({pix_bus.pix_valid, busy, addr_err}), 0);
    start_frame();
    check("ar_restart", 32'(busy), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
